// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// ALU operation codes and datapath mux selects.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [6:0] OP_LW  = 7'd3;
    localparam logic [6:0] OP_SW  = 7'd35;
    localparam logic [6:0] OP_R   = 7'd51;
    localparam logic [6:0] OP_I   = 7'd19;
    localparam logic [6:0] OP_BEQ = 7'd99;
    localparam logic [6:0] OP_JAL = 7'd111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Instruction fields, status flags and datapath control lines between the
// control unit (master) and the datapath (slave).
interface mc_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       mem_ready;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [2:0] ALUControl;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic       halted;

    modport master (
        input  op, funct3, funct7b5, Zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
               ALUSrcA, ALUSrcB, ImmSrc, RegWrite, halted
    );

    modport slave (
        output op, funct3, funct7b5, Zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
               ALUSrcA, ALUSrcB, ImmSrc, RegWrite, halted
    );
endinterface

// File: rtl/mc_controller_alu_decoder.sv
// Maps the FSM's ALUOp plus instruction funct fields onto an ALU operation.
module alu_decoder
    import riscv_pkg::*;
(
    input  aluop_t     aluop_i,
    input  logic [2:0] funct3_i,
    input  logic       op5_i,
    input  logic       funct7b5_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (aluop_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // funct7b5 only means sub for R-type; addi immediates may set it
                    3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Moore control FSM for the multicycle RV32I core; sequences fetch, decode,
// execute, memory and writeback over the shared datapath.
module mc_controller
    import riscv_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic          clk,
    input  logic          reset,
    mc_controller_if.master bus
);

    state_t state_q, state_d;
    aluop_t aluop;
    logic   pc_write, mem_write, ir_write, reg_write, halt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= RESET_STATE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d           = state_q;
        aluop             = ALUOP_ADD;
        pc_write          = 1'b0;
        mem_write         = 1'b0;
        ir_write          = 1'b0;
        reg_write         = 1'b0;
        halt              = 1'b0;
        bus.AdrSrc        = 1'b0;
        bus.ResultSrc     = RES_ALUOUT;
        bus.ALUSrcA       = SRCA_PC;
        bus.ALUSrcB       = SRCB_RS2;

        case (state_q)
            S_FETCH: begin
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURESULT;
                ir_write      = bus.mem_ready;
                pc_write      = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_IMM;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUSrcB = SRCB_IMM;
                state_d     = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                bus.AdrSrc = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                bus.ResultSrc = RES_DATA;
                reg_write     = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                bus.AdrSrc = 1'b1;
                mem_write  = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                bus.ALUSrcA = SRCA_RS1;
                aluop       = ALUOP_FUNCT;
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUSrcB = SRCB_IMM;
                aluop       = ALUOP_FUNCT;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQ: begin
                bus.ALUSrcA = SRCA_RS1;
                aluop       = ALUOP_SUB;
                pc_write    = bus.Zero;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_FOUR;
                pc_write    = 1'b1;
                state_d     = S_ALUWB;
            end
            S_HALT: begin
                halt    = 1'b1;
                state_d = S_HALT;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Enables are masked while reset is held so nothing commits during reset
    assign bus.PCWrite  = pc_write  & ~reset;
    assign bus.MemWrite = mem_write & ~reset;
    assign bus.IRWrite  = ir_write  & ~reset;
    assign bus.RegWrite = reg_write & ~reset;
    assign bus.halted   = halt      & ~reset;
    assign bus.ImmSrc   = imm_sel(bus.op);

    alu_decoder u_alu_decoder (
        .aluop_i       (aluop),
        .funct3_i      (bus.funct3),
        .op5_i         (bus.op[5]),
        .funct7b5_i    (bus.funct7b5),
        .alu_control_o (bus.ALUControl)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Directed cycle-by-cycle check of the control unit outputs for each
// instruction class, memory stalls, asynchronous reset and the halt trap.
module tb_mc_controller;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    mc_controller_if bus ();

    mc_controller #(.RESET_STATE(S_FETCH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUControl,ALUSrcA,ALUSrcB,ImmSrc,RegWrite,halted}
    function automatic logic [16:0] ev(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic [1:0] rs,
                                       input logic [2:0] alu, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] imm,
                                       input logic rw, input logic h);
        return {pcw, adr, mw, irw, rs, alu, sa, sb, imm, rw, h};
    endfunction

    task automatic chk(input string tag, input logic [16:0] expv);
        logic [16:0] obs;
        obs = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
               bus.ALUControl, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.RegWrite,
               bus.halted};
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic f7, input logic z, input logic mr,
                       input logic [16:0] expv);
        @(negedge clk);
        bus.op        = op;
        bus.funct3    = f3;
        bus.funct7b5  = f7;
        bus.Zero      = z;
        bus.mem_ready = mr;
        #1;
        chk(tag, expv);
    endtask

    initial begin
        reset         = 1'b1;
        bus.op        = 7'd0;
        bus.funct3    = 3'd0;
        bus.funct7b5  = 1'b0;
        bus.Zero      = 1'b0;
        bus.mem_ready = 1'b0;

        @(negedge clk); #1;
        chk("reset_state", ev(0,0,0,0,2'b10,3'b000,2'b00,2'b10,2'b00,0,0));
        bus.mem_ready = 1'b1;
        #1;
        chk("reset_irwrite_masked", ev(0,0,0,0,2'b10,3'b000,2'b00,2'b10,2'b00,0,0));
        bus.mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // R-type sub: 4 cycles
        cyc("r_fetch",  OP_R, 3'b000, 1, 0, 1, ev(1,0,0,1,2'b10,3'b000,2'b00,2'b10,2'b00,0,0));
        cyc("r_decode", OP_R, 3'b000, 1, 0, 1, ev(0,0,0,0,2'b00,3'b000,2'b01,2'b01,2'b00,0,0));
        cyc("r_execr",  OP_R, 3'b000, 1, 0, 1, ev(0,0,0,0,2'b00,3'b001,2'b10,2'b00,2'b00,0,0));
        cyc("r_aluwb",  OP_R, 3'b000, 1, 0, 1, ev(0,0,0,0,2'b00,3'b000,2'b00,2'b00,2'b00,1,0));

        // I-type ori
        cyc("i_fetch",  OP_I, 3'b110, 1, 0, 1, ev(1,0,0,1,2'b10,3'b000,2'b00,2'b10,2'b00,0,0));
        cyc("i_decode", OP_I, 3'b110, 1, 0, 1, ev(0,0,0,0,2'b00,3'b000,2'b01,2'b01,2'b00,0,0));
        cyc("i_execi",  OP_I, 3'b110, 1, 0, 1, ev(0,0,0,0,2'b00,3'b010,2'b10,2'b01,2'b00,0,0));
        cyc("i_aluwb",  OP_I, 3'b110, 1, 0, 1, ev(0,0,0,0,2'b00,3'b000,2'b00,2'b00,2'b00,1,0));

        // R-type slt
        cyc("slt_fetch",  OP_R, 3'b010, 0, 0, 1, ev(1,0,0,1,2'b10,3'b000,2'b00,2'b10,2'b00,0,0));
        cyc("slt_decode", OP_R, 3'b010, 0, 0, 1, ev(0,0,0,0,2'b00,3'b000,2'b01,2'b01,2'b00,0,0));
        cyc("slt_execr",  OP_R, 3'b010, 0, 0, 1, ev(0,0,0,0,2'b00,3'b101,2'b10,2'b00,2'b00,0,0));
        cyc("slt_aluwb",  OP_R, 3'b010, 0, 0, 1, ev(0,0,0,0,2'b00,3'b000,2'b00,2'b00,2'b00,1,0));

        // lw with two stall cycles in MEMREAD: 7 cycles
        cyc("lw_fetch",   OP_LW, 3'b010, 0, 0, 1, ev(1,0,0,1,2'b10,3'b000,2'b00,2'b10,2'b00,0,0));
        cyc("lw_decode",  OP_LW, 3'b010, 0, 0, 1, ev(0,0,0,0,2'b00,3'b000,2'b01,2'b01,2'b00,0,0));
        cyc("lw_memadr",  OP_LW, 3'b010, 0, 0, 1, ev(0,0,0,0,2'b00,3'b000,2'b10,2'b01,2'b00,0,0));
        cyc("lw_rd_st1",  OP_LW, 3'b010, 0, 0, 0, ev(0,1,0,0,2'b00,3'b000,2'b00,2'b00,2'b00,0,0));
        cyc("lw_rd_st2",  OP_LW, 3'b010, 0, 0, 0, ev(0,1,0,0,2'b00,3'b000,2'b00,2'b00,2'b00,0,0));
        cyc("lw_rd_done", OP_LW, 3'b010, 0, 0, 1, ev(0,1,0,0,2'b00,3'b000,2'b00,2'b00,2'b00,0,0));
        cyc("lw_memwb",   OP_LW, 3'b010, 0, 0, 1, ev(0,0,0,0,2'b01,3'b000,2'b00,2'b00,2'b00,1,0));

        // beq taken then not taken: 3 cycles each
        cyc("beq1_fetch",  OP_BEQ, 3'b000, 0, 1, 1, ev(1,0,0,1,2'b10,3'b000,2'b00,2'b10,2'b10,0,0));
        cyc("beq1_decode", OP_BEQ, 3'b000, 0, 1, 1, ev(0,0,0,0,2'b00,3'b000,2'b01,2'b01,2'b10,0,0));
        cyc("beq1_taken",  OP_BEQ, 3'b000, 0, 1, 1, ev(1,0,0,0,2'b00,3'b001,2'b10,2'b00,2'b10,0,0));
        cyc("beq0_fetch",  OP_BEQ, 3'b000, 0, 0, 1, ev(1,0,0,1,2'b10,3'b000,2'b00,2'b10,2'b10,0,0));
        cyc("beq0_decode", OP_BEQ, 3'b000, 0, 0, 1, ev(0,0,0,0,2'b00,3'b000,2'b01,2'b01,2'b10,0,0));
        cyc("beq0_ntaken", OP_BEQ, 3'b000, 0, 0, 1, ev(0,0,0,0,2'b00,3'b001,2'b10,2'b00,2'b10,0,0));

        // jal: 4 cycles
        cyc("jal_fetch",  OP_JAL, 3'b000, 0, 0, 1, ev(1,0,0,1,2'b10,3'b000,2'b00,2'b10,2'b11,0,0));
        cyc("jal_decode", OP_JAL, 3'b000, 0, 0, 1, ev(0,0,0,0,2'b00,3'b000,2'b01,2'b01,2'b11,0,0));
        cyc("jal_jal",    OP_JAL, 3'b000, 0, 0, 1, ev(1,0,0,0,2'b00,3'b000,2'b01,2'b10,2'b11,0,0));
        cyc("jal_aluwb",  OP_JAL, 3'b000, 0, 0, 1, ev(0,0,0,0,2'b00,3'b000,2'b00,2'b00,2'b11,1,0));

        // sw with a fetch stall, then reset mid-MEMWRITE stall
        cyc("sw_fetch_st", OP_SW, 3'b010, 0, 0, 0, ev(0,0,0,0,2'b10,3'b000,2'b00,2'b10,2'b01,0,0));
        cyc("sw_fetch",    OP_SW, 3'b010, 0, 0, 1, ev(1,0,0,1,2'b10,3'b000,2'b00,2'b10,2'b01,0,0));
        cyc("sw_decode",   OP_SW, 3'b010, 0, 0, 1, ev(0,0,0,0,2'b00,3'b000,2'b01,2'b01,2'b01,0,0));
        cyc("sw_memadr",   OP_SW, 3'b010, 0, 0, 1, ev(0,0,0,0,2'b00,3'b000,2'b10,2'b01,2'b01,0,0));
        cyc("sw_wr_stall", OP_SW, 3'b010, 0, 0, 0, ev(0,1,1,0,2'b00,3'b000,2'b00,2'b00,2'b01,0,0));
        cyc("sw_wr_hold",  OP_SW, 3'b010, 0, 0, 0, ev(0,1,1,0,2'b00,3'b000,2'b00,2'b00,2'b01,0,0));
        #1 reset = 1'b1;
        #1;
        chk("rst_async_fetch", ev(0,0,0,0,2'b10,3'b000,2'b00,2'b10,2'b01,0,0));
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1;
        chk("rst_hold_irw0", ev(0,0,0,0,2'b10,3'b000,2'b00,2'b10,2'b01,0,0));
        @(negedge clk);
        bus.mem_ready = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_rel_fetch_st", ev(0,0,0,0,2'b10,3'b000,2'b00,2'b10,2'b01,0,0));
        bus.mem_ready = 1'b1;
        #1;
        chk("rst_rel_fetch", ev(1,0,0,1,2'b10,3'b000,2'b00,2'b10,2'b01,0,0));

        // illegal opcode traps into HALT and stays there
        cyc("ill_decode", 7'h7F, 3'b000, 0, 0, 1, ev(0,0,0,0,2'b00,3'b000,2'b01,2'b01,2'b00,0,0));
        for (int unsigned i = 0; i < 20; i++) begin
            cyc("halt_hold", 7'h7F, 3'b000, 0, i[0], i[1],
                ev(0,0,0,0,2'b00,3'b000,2'b00,2'b00,2'b00,0,1));
        end
        #1 reset = 1'b1;
        #1;
        chk("halt_reset_clear", ev(0,0,0,0,2'b10,3'b000,2'b00,2'b10,2'b00,0,0));
        @(negedge clk);
        reset = 1'b0;
        bus.op = OP_R;
        bus.mem_ready = 1'b1;
        #1;
        chk("post_halt_fetch", ev(1,0,0,1,2'b10,3'b000,2'b00,2'b10,2'b00,0,0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d required=finish", checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Main control unit for the multicycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal).
- Sequences the shared datapath (one ALU, one unified instruction/data memory, IR/OldPC/A/ALUOut registers) through a Moore state machine.
- Decodes the instruction held in the IR into ALU, immediate and mux selects.
- A memory ready handshake stretches fetch and data-access states.

Parameters:
RESET_STATE, S_FETCH, state entered on reset (kept as a parameter for bench start-up only)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
op  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7b5  in  1  IR[30]
Zero  in  1  ALU zero flag, valid in the S_BEQ cycle
mem_ready  in  1  memory completed the current access this cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut/Result
MemWrite  out  1  data write strobe
IRWrite  out  1  IR and OldPC enable
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ALUControl  out  3  000 add, 001 sub, 010 or, 011 and, 101 slt
ALUSrcA  out  2  00=PC, 01=OldPC, 10=A(rs1)
ALUSrcB  out  2  00=B(rs2), 01=ImmExt, 10=constant 4
ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
RegWrite  out  1  register file write enable
halted  out  1  illegal opcode trapped; sticky

Behaviour:
Clock, reset and output timing:
- One clock; reset is asynchronous and active-high.
- All state changes on the rising edge of clk.
- Reset forces state to S_FETCH immediately, mid-instruction included.
- While reset is high, PCWrite/IRWrite/MemWrite/RegWrite/halted are 0. Other outputs take their S_FETCH values.
- All outputs are combinational from state plus op/funct/Zero/mem_ready. They hold no registers beyond state.

Immediate select (ImmSrc):
- Decoded from op in every state: 3/19 -> 00, 35 -> 01, 99 -> 10, 111 -> 11.
- Any other op -> 00.

ALU control:
- ALUOp is an internal 2-bit signal: 00 add, 01 sub, 10 decode from funct.
- Decode from funct:
  - {funct3,op[5],funct7b5} = 000_11 -> sub.
  - funct3 = 000 otherwise -> add.
  - funct3 = 010 -> slt; 110 -> or; 111 -> and.
  - Any other funct3 -> add.

States and outputs (any output not listed is 0/00):
- S_FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCWrite=mem_ready. Stay in S_FETCH while mem_ready=0; go to S_DECODE when 1.
- S_DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by op:
  - 3 or 35 -> S_MEMADR
  - 51 -> S_EXECR
  - 19 -> S_EXECI
  - 99 -> S_BEQ
  - 111 -> S_JAL
  - any other -> S_HALT
- S_MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next is S_MEMREAD if op=3, else S_MEMWRITE.
- S_MEMREAD: AdrSrc=1, ResultSrc=00. Wait for mem_ready, then go to S_MEMWB.
- S_MEMWB: ResultSrc=01, RegWrite=1. Next is S_FETCH.
- S_MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. MemWrite is held every cycle until mem_ready=1, then go to S_FETCH.
- S_EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next is S_ALUWB.
- S_EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next is S_ALUWB.
- S_ALUWB: ResultSrc=00, RegWrite=1. Next is S_FETCH.
- S_BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00. PCWrite=Zero. Next is S_FETCH.
- S_JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Next is S_ALUWB (writes PC+4 to rd).
- S_HALT: halted=1, all enables 0. Stays in S_HALT until reset.

Latency with mem_ready tied high:
- beq: 3 cycles.
- R-type, I-type, sw, jal: 4 cycles.
- lw: 5 cycles.
- Each cycle with mem_ready=0 in S_FETCH, S_MEMREAD or S_MEMWRITE adds 1 cycle.

Invariants:
- At most one of RegWrite/MemWrite/IRWrite is high in any cycle.
- PCWrite never rises outside S_FETCH, S_BEQ and S_JAL.

Decomposition:
- Package riscv_pkg:
  - state enum, 4 bits: S_FETCH=0 … S_HALT=11
  - opcode constants: OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL
  - ALUControl encodings
  - ALUSrcA/ALUSrcB/ResultSrc/ImmSrc select encodings
- One combinational sub-module, alu_decoder: inputs ALUOp, funct3, op[5], funct7b5; output ALUControl.

Test Plan:
- Reset high in S_MEMWRITE with mem_ready=0 -> state S_FETCH asynchronously; MemWrite drops to 0 the same cycle; IRWrite=0 until reset falls.
- R-type sub (op=51, funct3=000, funct7b5=1), mem_ready=1 -> 4 cycles; ALUControl=001 in S_EXECR; RegWrite=1 only in cycle 4.
- lw (op=3) with mem_ready low for 2 cycles in S_MEMREAD -> 7 cycles total; RegWrite=1 with ResultSrc=01 in the final cycle.
- beq (op=99) with Zero=1, then Zero=0 -> PCWrite=1, then 0, in the S_BEQ cycle; ALUControl=001; 3 cycles each.
- jal (op=111) -> ImmSrc=11; PCWrite=1 in S_JAL; RegWrite=1 next cycle; back in S_FETCH after 4 cycles.
- op=7'h7F in S_DECODE -> S_HALT; halted=1; no enables for 20 cycles; reset clears halted=0.
